comparador_patrones: RTL and testbench
======================================

# comparador_patrones

Registered, parametrised pattern comparator for the Morse transmitter datapath. It extends the fixed 5-bit equality comparison to a programmable table of ENTRIES masked reference patterns. Each accepted input word is checked against every valid entry in parallel, and the block reports hit, lowest matching index and multi-hit flag one cycle later. It also keeps a saturating hit counter. It sits between the symbol encoder and the transmit control FSM and classifies incoming symbol codes.

## Interface
- WIDTH, 5, data/pattern width in bits (≥1)
- ENTRIES, 4, number of pattern table entries (≥2)
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden)
- CNT_W, 8, hit counter width (≥2)

- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cfg_we  input  1  write table entry cfg_idx this cycle
- cfg_idx  input  IDX_W  entry to write; values ≥ENTRIES ignored
- cfg_patron  input  WIDTH  reference pattern
- cfg_mascara  input  WIDTH  compare mask, 1 = bit participates
- cfg_clear  input  1  invalidate all entries
- in_valid  input  1  in_dato valid; always accepted (no backpressure)
- in_dato  input  WIDTH  word to classify
- cnt_clr  input  1  clear hit counter
- out_valid  output  1  result valid, one-cycle pulse per accepted input
- out_coincide  output  1  at least one valid entry matched
- out_indice  output  IDX_W  lowest matching entry index, 0 if no match
- out_multiple  output  1  two or more entries matched
- out_cuenta  output  CNT_W  saturating count of matching inputs

## Operation
- Table: per entry patron[WIDTH], mascara[WIDTH], valido bit.
- Entry write on cfg_we with cfg_idx<ENTRIES stores patron and mascara and sets valido=1. A write to an out-of-range cfg_idx leaves the table unchanged.
- cfg_clear clears every valido bit. Patterns and masks are unchanged. It has priority over a cfg_we in the same cycle, so the net result is all entries invalid.
- Entry i hits when valido[i] & (((in_dato ^ patron[i]) & mascara[i]) == 0).
- A valid entry with all-zero mask matches any input. An invalid entry never matches.
- When in_valid=1 the following are registered on the next edge:
  - out_coincide = OR of hits
  - out_indice = lowest hit index (priority encoder, 0 when none)
  - out_multiple = popcount(hits) ≥ 2
- When in_valid=0: out_valid=0. The other result outputs hold their last values.
- Counter: it increments by 1 on each accepted input that hits. It saturates at 2^CNT_W−1 and does not wrap.
- cnt_clr forces the counter to 0 and wins over a simultaneous increment.
- Compare and configuration in the same cycle: the compare uses the table contents before the edge. A write or clear affects only inputs accepted from the next cycle on.

## Timing
- Reset (rst_n=0, asynchronous): all valido=0, patrones=0, mascaras=0, out_valid=0, out_coincide=0, out_indice=0, out_multiple=0, out_cuenta=0. All outputs are 0 while rst_n is held low.
- Reset release is synchronous to clk. The first input can be accepted on the first rising edge with rst_n=1.
- Latency: in_valid at edge N gives out_valid=1 and results after edge N, visible in cycle N+1.
- Throughput: one word per cycle, back-to-back supported.
- out_cuenta updates on the same edge as the corresponding out_valid.
- A reset asserted mid-stream discards any in-flight result. No out_valid is produced for it.
- All outputs are driven directly from registers, with no combinational path from inputs to outputs.

## Test plan
- Reset then input: after reset, in_dato=5'b10110 with in_valid=1 → out_valid=1, out_coincide=0, out_indice=0, out_multiple=0, out_cuenta=0.
- Exact match: write entry 2 with patron 5'b10110 and mascara 5'b11111, then send 5'b10110 → out_coincide=1, out_indice=2, out_multiple=0, out_cuenta=1. Sending 5'b10111 next gives out_coincide=0 and out_cuenta stays 1.
- Mask and priority: write entry 1 with patron 5'b10000 and mascara 5'b10000, and entry 3 with patron 5'b10110 and mascara 5'b11111. Send 5'b10110 → out_indice=1, out_multiple=1.
- Same-cycle config: write entry 0 with patron 5'b00001 and mascara 5'b11111 while in_dato=5'b00001 is valid → no hit that cycle. The same input on the next cycle → hit, out_indice=0. Then assert cfg_clear together with cfg_we → all entries invalid and no further hits.
- Counter boundaries: with CNT_W=2, send 5 hitting inputs → out_cuenta sequence 1,2,3,3,3. Assert cnt_clr together with a hit → out_cuenta=0.
- Async reset mid-stream: drop rst_n between two back-to-back valid inputs → all outputs 0 immediately with no clock edge needed. After release, the table is empty and the next input gives no hit.

Source files
------------

// File: rtl/comparador_patrones.sv
// Masked pattern table comparator: classifies each accepted symbol code against
// ENTRIES programmable reference patterns and reports hit, lowest index and multi-hit.
module comparador_patrones #(
  parameter  int WIDTH   = 5,
  parameter  int ENTRIES = 4,
  parameter  int CNT_W   = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [WIDTH-1:0] cfg_patron,
  input  logic [WIDTH-1:0] cfg_mascara,
  input  logic             cfg_clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_dato,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             out_coincide,
  output logic [IDX_W-1:0] out_indice,
  output logic             out_multiple,
  output logic [CNT_W-1:0] out_cuenta
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] patron_reg  [ENTRIES];
  logic [WIDTH-1:0] mascara_reg [ENTRIES];
  logic [ENTRIES-1:0] valido_reg;

  logic [ENTRIES-1:0] sel;
  logic [ENTRIES-1:0] hit;

  logic             valid_reg;
  logic             coincide_reg;
  logic [IDX_W-1:0] indice_reg;
  logic             multiple_reg;
  logic [CNT_W-1:0] cuenta_reg;

  logic             coincide_next;
  logic [IDX_W-1:0] indice_next;
  logic             multiple_next;
  logic [CNT_W-1:0] cuenta_next;

  // Out-of-range indices (non power-of-two ENTRIES) decode to no entry at all.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign sel[gi] = cfg_we && (cfg_idx == IDX_W'(gi));
      assign hit[gi] = valido_reg[gi] &&
                       (((in_dato ^ patron_reg[gi]) & mascara_reg[gi]) == '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valido_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        patron_reg[i]  <= '0;
        mascara_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (sel[i]) begin
          patron_reg[i]  <= cfg_patron;
          mascara_reg[i] <= cfg_mascara;
        end
        // Clear beats a same-cycle write so the table ends fully invalid.
        if (cfg_clear)
          valido_reg[i] <= 1'b0;
        else if (sel[i])
          valido_reg[i] <= 1'b1;
      end
    end
  end

  // Lowest index wins; a second hit flags multiple.
  always_comb begin
    coincide_next = 1'b0;
    indice_next   = '0;
    multiple_next = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (hit[i]) begin
        if (coincide_next)
          multiple_next = 1'b1;
        else
          indice_next = IDX_W'(i);
        coincide_next = 1'b1;
      end
    end
  end

  always_comb begin
    cuenta_next = cuenta_reg;
    if (cnt_clr)
      cuenta_next = '0;
    else if (in_valid && coincide_next && (cuenta_reg != CNT_MAX))
      cuenta_next = cuenta_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      coincide_reg <= 1'b0;
      indice_reg   <= '0;
      multiple_reg <= 1'b0;
      cuenta_reg   <= '0;
    end else begin
      valid_reg  <= in_valid;
      cuenta_reg <= cuenta_next;
      if (in_valid) begin
        coincide_reg <= coincide_next;
        indice_reg   <= indice_next;
        multiple_reg <= multiple_next;
      end
    end
  end

  assign out_valid    = valid_reg;
  assign out_coincide = coincide_reg;
  assign out_indice   = indice_reg;
  assign out_multiple = multiple_reg;
  assign out_cuenta   = cuenta_reg;

endmodule

// File: tb/tb_comparador_patrones.sv
// Scoreboard bench for comparador_patrones: directed vectors push expected results,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_comparador_patrones;

  localparam int WIDTH   = 5;
  localparam int ENTRIES = 4;
  localparam int CNT_W   = 2;
  localparam int IDX_W   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_idx = '0;
  logic [WIDTH-1:0] cfg_patron = '0;
  logic [WIDTH-1:0] cfg_mascara = '0;
  logic             cfg_clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_dato = '0;
  logic             cnt_clr = 1'b0;
  logic             out_valid;
  logic             out_coincide;
  logic [IDX_W-1:0] out_indice;
  logic             out_multiple;
  logic [CNT_W-1:0] out_cuenta;

  comparador_patrones #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_patron(cfg_patron),
    .cfg_mascara(cfg_mascara), .cfg_clear(cfg_clear),
    .in_valid(in_valid), .in_dato(in_dato), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_coincide(out_coincide), .out_indice(out_indice),
    .out_multiple(out_multiple), .out_cuenta(out_cuenta)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             coin;
    logic [IDX_W-1:0] idx;
    logic             mult;
    logic [CNT_W-1:0] cnt;
    int               cyc;
    int               tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tag = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end else
      $display("ok   %s = %0d", nm, act);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual 1 required 0 at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk($sformatf("t%0d_latency", e.tag), cyc, e.cyc);
        chk($sformatf("t%0d_coincide", e.tag), out_coincide, e.coin);
        chk($sformatf("t%0d_indice", e.tag), out_indice, e.idx);
        chk($sformatf("t%0d_multiple", e.tag), out_multiple, e.mult);
        chk($sformatf("t%0d_cuenta", e.tag), out_cuenta, e.cnt);
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic c, input logic [IDX_W-1:0] i,
                      input logic m, input logic [CNT_W-1:0] n);
    exp_t x;
    x.coin = c; x.idx = i; x.mult = m; x.cnt = n; x.cyc = cyc + 1; x.tag = tag;
    tag++;
    q.push_back(x);
    in_valid = 1'b1;
    in_dato  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wr(input logic [IDX_W-1:0] i, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] m);
    cfg_we = 1'b1; cfg_idx = i; cfg_patron = p; cfg_mascara = m;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_coincide"}, out_coincide, 0);
    chk({nm, "_indice"}, out_indice, 0);
    chk({nm, "_multiple"}, out_multiple, 0);
    chk({nm, "_cuenta"}, out_cuenta, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Empty table: no hit
    send(5'b10110, 0, 0, 0, 0);

    // Exact match on entry 2, then a one-bit miss
    wr(2, 5'b10110, 5'b11111);
    send(5'b10110, 1, 2, 0, 1);
    send(5'b10111, 0, 0, 0, 1);

    // Masked entry 1 and full entry 3 also hit: priority and multi-hit
    wr(1, 5'b10000, 5'b10000);
    wr(3, 5'b10110, 5'b11111);
    send(5'b10110, 1, 1, 1, 2);

    // Idle cycle: results hold, out_valid drops
    @(posedge clk); #1;
    chk("hold_valid", out_valid, 0);
    chk("hold_coincide", out_coincide, 1);
    chk("hold_indice", out_indice, 1);
    chk("hold_multiple", out_multiple, 1);

    // Write and compare in the same cycle: old table used
    cfg_we = 1'b1; cfg_idx = 0; cfg_patron = 5'b00001; cfg_mascara = 5'b11111;
    send(5'b00001, 0, 0, 0, 2);
    cfg_we = 1'b0;
    send(5'b00001, 1, 0, 0, 3);

    // Counter clear, then saturation at 3
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("cnt_clr_alone", out_cuenta, 0);
    send(5'b00001, 1, 0, 0, 1);
    send(5'b00001, 1, 0, 0, 2);
    send(5'b00001, 1, 0, 0, 3);
    send(5'b00001, 1, 0, 0, 3);
    send(5'b00001, 1, 0, 0, 3);
    cnt_clr = 1'b1;
    send(5'b00001, 1, 0, 0, 0);
    cnt_clr = 1'b0;

    // Clear beats a simultaneous write
    cfg_clear = 1'b1;
    wr(0, 5'b00001, 5'b11111);
    cfg_clear = 1'b0;
    send(5'b00001, 0, 0, 0, 0);
    send(5'b10110, 0, 0, 0, 0);

    // Async reset between two back-to-back inputs
    wr(2, 5'b10110, 5'b11111);
    send(5'b10110, 1, 2, 0, 1);
    in_valid = 1'b1;
    in_dato  = 5'b10110;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    send(5'b10110, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
